// File: rtl/gb_timer_pkg.sv
// Shared constants for the Game Boy timer block: register offsets, TAC tick
// select encodings and overflow-delay state encodings.
package gb_timer_pkg;

    localparam logic [1:0] DIV_OFS  = 2'd0;
    localparam logic [1:0] TIMA_OFS = 2'd1;
    localparam logic [1:0] TMA_OFS  = 2'd2;
    localparam logic [1:0] TAC_OFS  = 2'd3;

    typedef enum logic [1:0] {
        TAC_SEL_4K   = 2'b00,
        TAC_SEL_262K = 2'b01,
        TAC_SEL_65K  = 2'b10,
        TAC_SEL_16K  = 2'b11
    } tac_sel_e;

    localparam int SEL_BIT_4K   = 9;
    localparam int SEL_BIT_262K = 3;
    localparam int SEL_BIT_65K  = 5;
    localparam int SEL_BIT_16K  = 7;

    localparam logic [7:0] TAC_READ_MASK = 8'hF8;

    localparam logic [0:0] OVF_IDLE  = 1'b0;
    localparam logic [0:0] OVF_DELAY = 1'b1;

    // Down-counter start value: TIMA sits at 00 for this many clocks plus one.
    localparam logic [1:0] OVF_DELAY_LAST = 2'd3;

endpackage

// File: rtl/gb_timer_prescaler.sv
// Free-running system counter with DIV clear, TAC tap select and the
// falling-edge detector that produces the TIMA increment strobe.
module gb_timer_prescaler
    import gb_timer_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       div_clr_i,
    input  logic [2:0] tac_i,
    output logic       inc_pulse_o,
    output logic [7:0] div_value_o
);

    logic [CNT_WIDTH-1:0] sys_cnt_q;
    logic [CNT_WIDTH-1:0] sys_cnt_d;
    logic                 prev_tick_q;
    logic                 sel;
    logic                 tick;

    always_comb begin
        if (div_clr_i) begin
            sys_cnt_d = '0;
        end else begin
            sys_cnt_d = sys_cnt_q + 1'b1;
        end
    end

    always_comb begin
        sel = 1'b0;
        case (tac_sel_e'(tac_i[1:0]))
            TAC_SEL_4K:   sel = sys_cnt_q[SEL_BIT_4K];
            TAC_SEL_262K: sel = sys_cnt_q[SEL_BIT_262K];
            TAC_SEL_65K:  sel = sys_cnt_q[SEL_BIT_65K];
            TAC_SEL_16K:  sel = sys_cnt_q[SEL_BIT_16K];
            default:      sel = 1'b0;
        endcase
    end

    // Gating by the enable bit means disabling the timer while the tap is
    // high also counts as a falling edge, as on the real part.
    assign tick        = sel & tac_i[2];
    assign inc_pulse_o = prev_tick_q & ~tick;
    assign div_value_o = sys_cnt_q[CNT_WIDTH-1 -: 8];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sys_cnt_q   <= '0;
            prev_tick_q <= 1'b0;
        end else begin
            sys_cnt_q   <= sys_cnt_d;
            prev_tick_q <= tick;
        end
    end

endmodule

// File: rtl/gb_timer_regs.sv
// Game Boy timer responder (DIV/TIMA/TMA/TAC) on the CPU bus.
// Define GB_TIMER_OVF_DELAY_EN for the one-M-cycle TIMA overflow reload delay.
module gb_timer_regs
    import gb_timer_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hFF04,
    parameter int          CNT_WIDTH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] addr_ext,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        rd_en,
    output logic        irq_timer,
    output logic [7:0]  div_value
);

    logic [15:0] ofs;
    logic        hit;
    logic [1:0]  reg_sel;
    logic        wr_div;
    logic        wr_tima;
    logic        wr_tma;
    logic        wr_tac;

    logic [7:0]  tima_q;
    logic [7:0]  tima_d;
    logic [7:0]  tma_q;
    logic [7:0]  tma_d;
    logic [2:0]  tac_q;
    logic [2:0]  tac_d;
    logic        irq_q;
    logic        irq_d;
    logic [7:0]  reload_val;
    logic        inc_pulse;

    assign ofs     = addr_ext - BASE_ADDR;
    assign hit     = (ofs[15:2] == 14'd0);
    assign reg_sel = ofs[1:0];

    assign wr_div  = mem_we & hit & (reg_sel == DIV_OFS);
    assign wr_tima = mem_we & hit & (reg_sel == TIMA_OFS);
    assign wr_tma  = mem_we & hit & (reg_sel == TMA_OFS);
    assign wr_tac  = mem_we & hit & (reg_sel == TAC_OFS);

    assign rd_en   = mem_re & ~mem_we & hit;

    gb_timer_prescaler #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_prescaler (
        .clock       (clock),
        .reset       (reset),
        .div_clr_i   (wr_div),
        .tac_i       (tac_q),
        .inc_pulse_o (inc_pulse),
        .div_value_o (div_value)
    );

    always_comb begin
        data_out = 8'h00;
        if (rd_en) begin
            case (reg_sel)
                DIV_OFS:  data_out = div_value;
                TIMA_OFS: data_out = tima_q;
                TMA_OFS:  data_out = tma_q;
                TAC_OFS:  data_out = TAC_READ_MASK | {5'b00000, tac_q};
                default:  data_out = 8'h00;
            endcase
        end
    end

    always_comb begin
        tma_d = wr_tma ? data_in : tma_q;
        tac_d = wr_tac ? data_in[2:0] : tac_q;
    end

    // A TMA write landing on the reload edge is what TIMA picks up.
    assign reload_val = wr_tma ? data_in : tma_q;

`ifdef GB_TIMER_OVF_DELAY_EN
    logic [0:0] ovf_state_q;
    logic [0:0] ovf_state_d;
    logic [1:0] dly_cnt_q;
    logic [1:0] dly_cnt_d;

    always_comb begin
        tima_d      = tima_q;
        irq_d       = 1'b0;
        ovf_state_d = ovf_state_q;
        dly_cnt_d   = dly_cnt_q;
        if (wr_tima) begin
            tima_d      = data_in;
            ovf_state_d = OVF_IDLE;
            dly_cnt_d   = 2'd0;
        end else if (ovf_state_q == OVF_DELAY) begin
            // Increments arriving while TIMA is parked at 00 are dropped.
            if (dly_cnt_q == 2'd0) begin
                tima_d      = reload_val;
                irq_d       = 1'b1;
                ovf_state_d = OVF_IDLE;
            end else begin
                dly_cnt_d = dly_cnt_q - 2'd1;
            end
        end else if (inc_pulse) begin
            if (tima_q == 8'hFF) begin
                tima_d      = 8'h00;
                ovf_state_d = OVF_DELAY;
                dly_cnt_d   = OVF_DELAY_LAST;
            end else begin
                tima_d = tima_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf_state_q <= OVF_IDLE;
            dly_cnt_q   <= 2'd0;
        end else begin
            ovf_state_q <= ovf_state_d;
            dly_cnt_q   <= dly_cnt_d;
        end
    end
`else
    always_comb begin
        tima_d = tima_q;
        irq_d  = 1'b0;
        if (wr_tima) begin
            tima_d = data_in;
        end else if (inc_pulse) begin
            if (tima_q == 8'hFF) begin
                tima_d = reload_val;
                irq_d  = 1'b1;
            end else begin
                tima_d = tima_q + 8'd1;
            end
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tima_q <= 8'h00;
            tma_q  <= 8'h00;
            tac_q  <= 3'b000;
            irq_q  <= 1'b0;
        end else begin
            tima_q <= tima_d;
            tma_q  <= tma_d;
            tac_q  <= tac_d;
            irq_q  <= irq_d;
        end
    end

    assign irq_timer = irq_q;

endmodule

// File: tb/tb_gb_timer_regs.sv
// Directed bench for gb_timer_regs: register table vectors, then cycle-exact
// sequences for DIV, overflow, collisions, the DIV-write glitch and reset.
module tb_gb_timer_regs;

    logic        clock;
    logic        reset;
    logic [15:0] addr_ext;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        rd_en;
    logic        irq_timer;
    logic [7:0]  div_value;

    int total;
    int bad;

`ifdef GB_TIMER_OVF_DELAY_EN
    localparam int OVF_LAT = 4;
`else
    localparam int OVF_LAT = 0;
`endif

    gb_timer_regs dut (
        .clock     (clock),
        .reset     (reset),
        .addr_ext  (addr_ext),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .data_in   (data_in),
        .data_out  (data_out),
        .rd_en     (rd_en),
        .irq_timer (irq_timer),
        .div_value (div_value)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] addr;
        logic        re;
        logic        we;
        logic [7:0]  data;
        logic [7:0]  exp_out;
        logic        exp_rd;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic re, input logic we, input logic [7:0] d);
        addr_ext = a;
        mem_re   = re;
        mem_we   = we;
        data_in  = d;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vecs[0]  = '{16'hFF07, 1'b1, 1'b0, 8'h00, 8'hF8, 1'b1};
        vecs[1]  = '{16'hFF05, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[2]  = '{16'hFF06, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[3]  = '{16'hFF04, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[4]  = '{16'hFF08, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[5]  = '{16'hFF03, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[6]  = '{16'hFF07, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0};
        vecs[7]  = '{16'hFF06, 1'b0, 1'b1, 8'h5A, 8'h00, 1'b0};
        vecs[8]  = '{16'hFF06, 1'b1, 1'b0, 8'h00, 8'h5A, 1'b1};
        vecs[9]  = '{16'hFF07, 1'b0, 1'b1, 8'hFB, 8'h00, 1'b0};
        vecs[10] = '{16'hFF07, 1'b1, 1'b0, 8'h00, 8'hFB, 1'b1};
        vecs[11] = '{16'hFF07, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0};
        vecs[12] = '{16'hFF07, 1'b1, 1'b0, 8'h00, 8'hF8, 1'b1};
        vecs[13] = '{16'hFF05, 1'b0, 1'b1, 8'hC3, 8'h00, 1'b0};
        vecs[14] = '{16'hFF05, 1'b1, 1'b0, 8'h00, 8'hC3, 1'b1};
        vecs[15] = '{16'hFF05, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};

        reset = 1'b1;
        drive(16'h0000, 1'b0, 1'b0, 8'h00);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_irq", {7'd0, irq_timer}, 8'h00);
        check("rst_rd_en", {7'd0, rd_en}, 8'h00);
        check("rst_data_out", data_out, 8'h00);
        check("rst_div", div_value, 8'h00);
        @(posedge clock);
        #1 reset = 1'b0;

        // Register access table, one vector per clock, sys_cnt 0..15
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].addr, vecs[i].re, vecs[i].we, vecs[i].data);
            @(negedge clock);
            check($sformatf("vec%0d_data", i), data_out, vecs[i].exp_out);
            check($sformatf("vec%0d_rd_en", i), {7'd0, rd_en}, {7'd0, vecs[i].exp_rd});
            step();
        end

        // DIV after 511 / 512 clocks from a DIV clear
        drive(16'hFF04, 1'b0, 1'b1, 8'h00);
        step();
        drive(16'h0000, 1'b0, 1'b0, 8'h00);
        repeat (511) step();
        drive(16'hFF04, 1'b1, 1'b0, 8'h00);
        @(negedge clock);
        check("div_511", data_out, 8'h01);
        step();
        @(negedge clock);
        check("div_512", data_out, 8'h02);
        check("div_value_512", div_value, 8'h02);
        step();

`ifdef GB_TIMER_OVF_DELAY_EN
        drive(16'hFF04, 1'b0, 1'b1, 8'h00); step();
        drive(16'hFF06, 1'b0, 1'b1, 8'h80); step();
        drive(16'hFF05, 1'b0, 1'b1, 8'hFF); step();
        drive(16'hFF07, 1'b0, 1'b1, 8'h05); step();
        drive(16'hFF05, 1'b1, 1'b0, 8'h00);
        repeat (13) step();
        @(negedge clock);
        check("dly_pre_ovf", data_out, 8'hFF);
        step();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check($sformatf("dly_hold%0d", i), data_out, 8'h00);
            check($sformatf("dly_hold_irq%0d", i), {7'd0, irq_timer}, 8'h00);
            step();
        end
        @(negedge clock);
        check("dly_reload", data_out, 8'h80);
        check("dly_irq_hi", {7'd0, irq_timer}, 8'h01);
        step();
        @(negedge clock);
        check("dly_irq_lo", {7'd0, irq_timer}, 8'h00);
        drive(16'hFF05, 1'b0, 1'b1, 8'hFF); step();
        drive(16'hFF05, 1'b1, 1'b0, 8'h00);
        repeat (10) step();
        @(negedge clock);
        check("dly2_hold", data_out, 8'h00);
        step();
        drive(16'hFF05, 1'b0, 1'b1, 8'h33); step();
        drive(16'hFF05, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check($sformatf("dly_cancel%0d", i), data_out, 8'h33);
            check($sformatf("dly_cancel_irq%0d", i), {7'd0, irq_timer}, 8'h00);
            step();
        end
`else
        // Overflow with bit3 tap: increments fall on sys_cnt 16, 32, 48, 64
        drive(16'hFF04, 1'b0, 1'b1, 8'h00); step();
        drive(16'hFF06, 1'b0, 1'b1, 8'hF0); step();
        drive(16'hFF05, 1'b0, 1'b1, 8'hFE); step();
        drive(16'hFF07, 1'b0, 1'b1, 8'h05); step();
        drive(16'hFF05, 1'b1, 1'b0, 8'h00);
        repeat (13) step();
        @(negedge clock);
        check("ovf_pre_inc", data_out, 8'hFE);
        step();
        @(negedge clock);
        check("ovf_first_inc", data_out, 8'hFF);
        repeat (15) step();
        @(negedge clock);
        check("ovf_hold_ff", data_out, 8'hFF);
        check("ovf_irq_pre", {7'd0, irq_timer}, 8'h00);
        step();
        @(negedge clock);
        check("ovf_reload", data_out, 8'hF0);
        check("ovf_irq_hi", {7'd0, irq_timer}, 8'h01);
        step();
        @(negedge clock);
        check("ovf_irq_lo", {7'd0, irq_timer}, 8'h00);
        check("ovf_after", data_out, 8'hF0);

        drive(16'hFF05, 1'b0, 1'b1, 8'hFF); step();
        drive(16'hFF05, 1'b1, 1'b0, 8'h00);
        @(negedge clock);
        check("col_setup", data_out, 8'hFF);
        repeat (13) step();
        drive(16'hFF05, 1'b0, 1'b1, 8'h42); step();
        drive(16'hFF05, 1'b1, 1'b0, 8'h00);
        @(negedge clock);
        check("col_tima", data_out, 8'h42);
        check("col_irq", {7'd0, irq_timer}, 8'h00);
        step();
        @(negedge clock);
        check("col_irq_next", {7'd0, irq_timer}, 8'h00);

        drive(16'hFF05, 1'b0, 1'b1, 8'hFF); step();
        drive(16'hFF05, 1'b1, 1'b0, 8'h00);
        repeat (13) step();
        drive(16'hFF06, 1'b0, 1'b1, 8'h77); step();
        drive(16'hFF05, 1'b1, 1'b0, 8'h00);
        @(negedge clock);
        check("tma_col_tima", data_out, 8'h77);
        check("tma_col_irq", {7'd0, irq_timer}, 8'h01);
        step();
        drive(16'hFF06, 1'b1, 1'b0, 8'h00);
        @(negedge clock);
        check("tma_col_tma", data_out, 8'h77);
        step();
`endif

        // DIV-write glitch with bit9 tap
        drive(16'hFF07, 1'b0, 1'b1, 8'h00); step();
        drive(16'hFF04, 1'b0, 1'b1, 8'h00); step();
        drive(16'hFF07, 1'b0, 1'b1, 8'h04); step();
        drive(16'hFF05, 1'b0, 1'b1, 8'h10); step();
        drive(16'h0000, 1'b0, 1'b0, 8'h00);
        repeat (598) step();
        @(negedge clock);
        check("glitch_div_600", div_value, 8'h02);
        drive(16'hFF04, 1'b0, 1'b1, 8'h00); step();
        drive(16'hFF05, 1'b1, 1'b0, 8'h00);
        @(negedge clock);
        check("glitch_div_clr", div_value, 8'h00);
        check("glitch_tima_pre", data_out, 8'h10);
        step();
        @(negedge clock);
        check("glitch_tima_inc", data_out, 8'h11);

        // Reset while the irq pulse is high
        drive(16'hFF05, 1'b0, 1'b1, 8'hFF); step();
        drive(16'hFF07, 1'b0, 1'b1, 8'h05); step();
        drive(16'hFF05, 1'b1, 1'b0, 8'h00);
        repeat (14 + OVF_LAT) step();
        @(negedge clock);
        check("rst_mid_irq_hi", {7'd0, irq_timer}, 8'h01);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_irq", {7'd0, irq_timer}, 8'h00);
        check("rst_mid_tima", data_out, 8'h00);
        check("rst_mid_div", div_value, 8'h00);
        drive(16'hFF07, 1'b1, 1'b0, 8'h00);
        #1;
        check("rst_mid_tac", data_out, 8'hF8);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        drive(16'h0000, 1'b0, 1'b0, 8'h00);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
